// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
//   sb_slot_t : one in-flight instruction (valid, dest, wb_en, is_load)
//   FWD_RF    : forwarding select value meaning "operand comes from the register file"
//   sel_width : width of a forwarding select for a given scoreboard depth
package hazard_pkg;

   // Destination field is sized for the widest register address supported.
   // Narrower ADDR_W values are zero-extended on entry, so compares stay exact.
   localparam int SB_DEST_W = 8;
   localparam int FWD_RF    = 0;

   typedef struct packed {
      logic                 valid;
      logic [SB_DEST_W-1:0] dest;
      logic                 wb_en;
      logic                 is_load;
   } sb_slot_t;

   function automatic int sel_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_src_match.sv
// Hazard check for a single source operand against the in-flight writers.
//   id_valid   : ID holds a real instruction
//   src        : source register number
//   src_used   : the source is actually read
//   slot_wr    : slot k holds a valid register writer (k = 1..DEPTH-1)
//   slot_dest  : destination of slot k (zero-extended)
//   slot1_load : the EXE slot holds a load
//   fwd_sel_i  : youngest matching slot (0 = register file)
//   stall_i    : this source requires a stall
module src_match
   import hazard_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 3,
   parameter int FWD_EN = 1,
   parameter int SEL_W  = sel_width(DEPTH)
) (
   input  logic                                 id_valid,
   input  logic [ADDR_W-1:0]                    src,
   input  logic                                 src_used,
   input  logic [DEPTH-1:1]                     slot_wr,
   input  logic [DEPTH-1:1][SB_DEST_W-1:0]      slot_dest,
   input  logic                                 slot1_load,
   output logic [SEL_W-1:0]                     fwd_sel_i,
   output logic                                 stall_i
);

   logic [SB_DEST_W-1:0] src_ext;
   logic [DEPTH-1:1]     hit;
   logic                 unused_ld;

   // Stall-only mode never looks at the load flag.
   assign unused_ld = slot1_load;
   assign src_ext   = SB_DEST_W'(src);

   // WB slot is not compared: the register file writes through.
   always_comb begin
      hit = '0;
      for (int k = 1; k < DEPTH; k++) begin
         hit[k] = id_valid & src_used & slot_wr[k] &
                  (slot_dest[k] == src_ext) & (src != '0);
      end
   end

   always_comb begin
      fwd_sel_i = SEL_W'(FWD_RF);
      stall_i   = 1'b0;
      if (FWD_EN != 0) begin
         // Walk oldest to youngest so the youngest match is the one left.
         for (int k = DEPTH - 1; k >= 1; k--) begin
            if (hit[k]) fwd_sel_i = SEL_W'(k);
         end
         // Youngest match is slot 1 exactly when hit[1] is set.
         stall_i = hit[1] & slot1_load;
      end else begin
         stall_i = |hit;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the in-order pipeline.
// Tracks in-flight writers from EXE onwards in a shift-register scoreboard and
// checks each ID source against it.
//   clock, reset      : rising-edge clock, async active-low reset
//   id_*              : instruction currently in ID
//   flush             : branch taken in EXE, kills the ID instruction
//   stall             : freeze PC/IFID, bubble into IDEXE
//   fwd_sel           : per-source operand select (0 = RF, k = slot k)
//   stall_count       : saturating count of stall cycles
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int ADDR_W  = 5,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 3,
   parameter int FWD_EN  = 1,
   parameter int CNT_W   = 16,
   parameter int SEL_W   = sel_width(DEPTH)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       id_valid,
   input  logic [NUM_SRC*ADDR_W-1:0]  id_src,
   input  logic [NUM_SRC-1:0]         id_src_used,
   input  logic [ADDR_W-1:0]          id_dest,
   input  logic                       id_wb_en,
   input  logic                       id_mem_read,
   input  logic                       flush,
   output logic                       stall,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
   output logic [CNT_W-1:0]           stall_count
);

   // Only slots 1..DEPTH-1 are stored: the WB slot can never cause a hazard
   // or be a forwarding source, so holding it would have no visible effect.
   sb_slot_t [DEPTH-1:1]            slots_q, slots_d;
   logic     [DEPTH-1:1]            slot_wr;
   logic     [DEPTH-1:1][SB_DEST_W-1:0] slot_dest;
   logic     [NUM_SRC-1:0]          src_stall;
   logic     [CNT_W-1:0]            cnt_q, cnt_d;
   logic                            unused_ld;

   // The oldest stored slot's load flag never matters: load-use is slot 1 only.
   assign unused_ld = slots_q[DEPTH-1].is_load;

   always_comb begin
      for (int k = 1; k < DEPTH; k++) begin
         slot_wr[k]   = slots_q[k].valid & slots_q[k].wb_en;
         slot_dest[k] = slots_q[k].dest;
      end
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      src_match #(
         .ADDR_W (ADDR_W),
         .DEPTH  (DEPTH),
         .FWD_EN (FWD_EN),
         .SEL_W  (SEL_W)
      ) u_src_match (
         .id_valid   (id_valid),
         .src        (id_src[i*ADDR_W +: ADDR_W]),
         .src_used   (id_src_used[i]),
         .slot_wr    (slot_wr),
         .slot_dest  (slot_dest),
         .slot1_load (slots_q[1].is_load),
         .fwd_sel_i  (fwd_sel[i*SEL_W +: SEL_W]),
         .stall_i    (src_stall[i])
      );
   end

   // A flushed ID instruction is being killed, so it must not hold the front end.
   assign stall = (|src_stall) & ~flush;

   always_comb begin
      slots_d = '0;
      if (id_valid & ~stall & ~flush) begin
         slots_d[1].valid   = 1'b1;
         slots_d[1].dest    = SB_DEST_W'(id_dest);
         slots_d[1].wb_en   = id_wb_en;
         slots_d[1].is_load = id_mem_read;
      end
      for (int k = 2; k < DEPTH; k++) begin
         slots_d[k] = slots_q[k-1];
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         slots_q <= '0;
         cnt_q   <= '0;
      end else begin
         slots_q <= slots_d;
         cnt_q   <= cnt_d;
      end
   end

   assign stall_count = cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard and forwarding controller for the in-order pipeline. It keeps its own shift-register scoreboard of in-flight writers from EXE through WB and compares each source register of the instruction in ID against it. It drives a stall to IF/IFID/ID and a per-source forwarding select to the EXE operand muxes. The block sits beside ID; the branch-taken flush from EXE is an input.

Parameters:
ADDR_W, 5, register address width
NUM_SRC, 2, number of source operands per instruction
DEPTH, 3, scoreboard slots after ID (slot 1 = EXE, slot DEPTH = WB); minimum 2
FWD_EN, 1, 1 = forwarding with load-use stall; 0 = stall-only interlock
CNT_W, 16, stall performance counter width
SEL_W, $clog2(DEPTH), forwarding select width (derived)

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_src  in  NUM_SRC*ADDR_W  source register numbers; source i at [i*ADDR_W +: ADDR_W]
id_src_used  in  NUM_SRC  source i is actually read
id_dest  in  ADDR_W  destination register of the ID instruction
id_wb_en  in  1  the ID instruction writes the register file
id_mem_read  in  1  the ID instruction is a load
flush  in  1  branch taken in EXE
stall  out  1  freeze PC/IFID and insert a bubble into IDEXE
fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = register file, k = result held in slot k (1..DEPTH-1)
stall_count  out  CNT_W  number of stall cycles, saturating

Behaviour:
- Reset: asynchronous, active-low. While reset is low, every slot is invalid and stall_count=0. stall and fwd_sel therefore read 0 for any ID inputs. Reset asserted mid-operation discards all in-flight entries immediately.
- Slot contents: valid, dest, wb_en, is_load.
- On each rising edge:
  - slot[k+1] <= slot[k] for k = 1..DEPTH-1.
  - slot[1] <= ID entry if id_valid & ~stall & ~flush; otherwise slot[1] becomes an invalid bubble.
  - slot[DEPTH] falls off on the following edge.
- Match condition for source i against slot k: id_valid, id_src_used[i], slot[k].valid, slot[k].wb_en, slot[k].dest == id_src[i], and id_src[i] != 0. Register 0 never matches.
- Slot DEPTH (WB) is never a hazard, because the register file is write-through. A match only in slot DEPTH gives fwd_sel=0 and no stall.
- FWD_EN=0:
  - stall = 1 if any source matches any slot 1..DEPTH-1.
  - fwd_sel is held at 0.
- FWD_EN=1:
  - For each source, take the youngest (lowest k) matching slot in 1..DEPTH-1; fwd_sel = k, or 0 if none matches.
  - stall = 1 only if that youngest match is slot 1 with is_load set (load-use). While stalled, fwd_sel still shows the combinational result.
- Flush has priority: flush=1 forces stall=0 because the ID instruction is being killed. The slot[1] bubble on the next edge follows from the slot rule above.
- stall and fwd_sel are combinational from slots and ID inputs; there is no added latency.
- stall_count increments on each edge where stall=1 and saturates at all-ones.
- Load-use latency: exactly 1 stall cycle with FWD_EN=1.
- Stall-only latency: a dependent instruction directly behind its producer stalls DEPTH-1 cycles with FWD_EN=0.

Decomposition:
- Package hazard_pkg:
  - sb_slot_t struct (valid, dest, wb_en, is_load)
  - FWD_RF = 0 constant
  - sel_width function
- One sub-module, src_match: compares one source against all slots and produces fwd_sel_i and stall_i. Instantiated NUM_SRC times with generate. The top ORs the stall_i outputs, then applies the flush and counter logic.

Test Plan:
1. Async reset: fill slots with writers to r1..r3, pull reset low between clock edges -> stall=0, fwd_sel=0 and stall_count=0 immediately, with no edge required.
2. FWD_EN=1 forwarding:
   - add r3 enters, next ID reads r3 as src0 -> fwd_sel[0]=1, stall=0.
   - One unrelated instruction between them -> fwd_sel[0]=2.
   - Two unrelated instructions between them (r3 in WB) -> fwd_sel[0]=0, stall=0.
3. FWD_EN=1 load-use: lw r4, then an instruction with src1=r4 -> stall=1 for 1 cycle, then fwd_sel[1]=2, stall=0, stall_count=1.
4. FWD_EN=0: add r3, then a reader of r3 -> stall=1 for 2 cycles, then fwd_sel=0, stall=0, stall_count=2.
5. Corner cases:
   - Writer with dest r0 followed by a reader of r0 -> no stall, fwd_sel=0.
   - Writers to r5 in slots 1 and 2 -> fwd_sel=1 (youngest wins).
   - id_src_used=0 for a matching source -> no effect.
6. Flush during load-use: lw r4 in slot 1, ID reads r4, flush=1 -> stall=0 and stall_count unchanged. Next cycle slot 1 is invalid and ID shows no hazard. Also preload stall_count to all-ones via a long stall and check it saturates.
